// File: rtl/data_mem_controller.sv
// data_mem_controller: in-order load/store responder queueing requests to a single-port SRAM.
// Define DATA_MEM_CONTROLLER_PERF_CNT_EN to add saturating perf_reads/perf_writes counters.
module data_mem_controller #(
    parameter int DEPTH  = 4,
    parameter int RAM_AW = 15
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              clk_en,
    input  logic [14:0]       mem_address,
    input  logic [1:0]        mem_mask,
    input  logic [1:0]        mem_read_fnc_type,
    input  logic [15:0]       mem_data,
    input  logic [1:0]        mem_mode,
    input  logic              mem_enable,
    input  logic [3:0]        mem_wb_dest,
    input  logic              mem_input_ready,
    output logic [15:0]       mem_data_out,
    output logic [3:0]        mem_wb_dest_out,
    output logic              mem_read_ack,
    output logic              mem_available,
    output logic              mem_idle,
    output logic              ram_en,
    output logic              ram_we,
    output logic [1:0]        ram_be,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
`ifdef DATA_MEM_CONTROLLER_PERF_CNT_EN
    output logic [15:0]       perf_reads,
    output logic [15:0]       perf_writes,
`endif
    output logic              fence_pulse,
    output logic [1:0]        fence_type_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] MODE_RD = 2'd0;
    localparam logic [1:0] MODE_WR = 2'd1;

    typedef struct packed {
        logic [1:0]  mode;
        logic [14:0] addr;
        logic [1:0]  mask;
        logic [1:0]  fnc;
        logic [15:0] data;
        logic [3:0]  tag;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RESP
    } state_t;

    req_t          queue_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [1:0]    rd_mask_q, rd_mask_d;
    logic [1:0]    rd_fnc_q, rd_fnc_d;
    logic [15:0]   rsp_data_q, rsp_data_d;
    logic [3:0]    rsp_tag_q, rsp_tag_d;
    logic          rsp_ack_q, rsp_ack_d;

    req_t          head;
    req_t          req_in;
    logic          head_vld;
    logic          head_rd;
    logic          head_wr;
    logic          head_fn;
    logic          push;
    logic          issue;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_fmt;

    always_comb begin
        head     = queue_q[rd_ptr_q];
        head_vld = (count_q != '0);
        head_rd  = (head.mode == MODE_RD);
        head_wr  = (head.mode == MODE_WR);
        head_fn  = head.mode[1];
        issue    = clk_en && head_vld && (state_q == S_IDLE);
        push     = clk_en && mem_enable && mem_available;
        req_in   = '{mode: mem_mode, addr: mem_address, mask: mem_mask,
                     fnc: mem_read_fnc_type, data: mem_data, tag: mem_wb_dest};
    end

    assign mem_available   = (count_q != CW'(DEPTH));
    assign mem_idle        = !head_vld && (state_q == S_IDLE);
    assign mem_read_ack    = rsp_ack_q;
    assign mem_data_out    = rsp_data_q;
    assign mem_wb_dest_out = rsp_tag_q;

    // Writes and fences retire in their issue cycle; only reads leave IDLE.
    assign ram_en         = issue && !head_fn;
    assign ram_we         = issue && head_wr;
    assign ram_be         = head.mask;
    assign ram_addr       = RAM_AW'(head.addr);
    assign ram_wdata      = head.data;
    assign fence_pulse    = issue && head_fn;
    assign fence_type_out = head.fnc;

    always_comb begin
        rd_byte = (rd_mask_q == 2'b10) ? ram_rdata[15:8] : ram_rdata[7:0];
        unique case (rd_fnc_q)
            2'b01:   rd_fmt = {8'h00, rd_byte};
            2'b10:   rd_fmt = {{8{rd_byte[7]}}, rd_byte};
            default: rd_fmt = ram_rdata;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push  ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + PW'(1) : rd_ptr_q;
        state_d    = state_q;
        rd_mask_d  = rd_mask_q;
        rd_fnc_d   = rd_fnc_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_ack_d  = rsp_ack_q;
        unique case ({push, issue})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        unique case (state_q)
            S_IDLE: begin
                if (issue && head_rd) begin
                    state_d   = S_RD_WAIT;
                    rd_mask_d = head.mask;
                    rd_fnc_d  = head.fnc;
                    rsp_tag_d = head.tag;
                end
            end
            S_RD_WAIT: begin
                if (clk_en) begin
                    rsp_data_d = rd_fmt;
                    rsp_ack_d  = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (clk_en && mem_input_ready) begin
                    rsp_ack_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            rd_mask_q  <= '0;
            rd_fnc_q   <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_ack_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            rd_mask_q  <= rd_mask_d;
            rd_fnc_q   <= rd_fnc_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_ack_q  <= rsp_ack_d;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else if (push) begin
            queue_q[wr_ptr_q] <= req_in;
        end
    end

`ifdef DATA_MEM_CONTROLLER_PERF_CNT_EN
    logic [15:0] perf_reads_q, perf_reads_d;
    logic [15:0] perf_writes_q, perf_writes_d;

    always_comb begin
        perf_reads_d  = perf_reads_q;
        perf_writes_d = perf_writes_q;
        if (ram_en && !ram_we && (perf_reads_q != 16'hFFFF)) begin
            perf_reads_d = perf_reads_q + 16'd1;
        end
        if (ram_en && ram_we && (perf_writes_q != 16'hFFFF)) begin
            perf_writes_d = perf_writes_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
        end else begin
            perf_reads_q  <= perf_reads_d;
            perf_writes_q <= perf_writes_d;
        end
    end

    assign perf_reads  = perf_reads_q;
    assign perf_writes = perf_writes_q;
`endif

endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: directed tables and sequences plus randomized traffic
// scored against an array/queue model of the request semantics.
`timescale 1ns/1ps
module tb_data_mem_controller;
    localparam int DEPTH  = 4;
    localparam int RAM_AW = 15;

    logic              clk;
    logic              async_rst_n;
    logic              clk_en;
    logic [14:0]       mem_address;
    logic [1:0]        mem_mask;
    logic [1:0]        mem_read_fnc_type;
    logic [15:0]       mem_data;
    logic [1:0]        mem_mode;
    logic              mem_enable;
    logic [3:0]        mem_wb_dest;
    logic              mem_input_ready;
    logic [15:0]       mem_data_out;
    logic [3:0]        mem_wb_dest_out;
    logic              mem_read_ack;
    logic              mem_available;
    logic              mem_idle;
    logic              ram_en;
    logic              ram_we;
    logic [1:0]        ram_be;
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;
    logic              fence_pulse;
    logic [1:0]        fence_type_out;
`ifdef DATA_MEM_CONTROLLER_PERF_CNT_EN
    logic [15:0]       perf_reads;
    logic [15:0]       perf_writes;
`endif

    data_mem_controller #(.DEPTH(DEPTH), .RAM_AW(RAM_AW)) dut (
        .clk               (clk),
        .async_rst_n       (async_rst_n),
        .clk_en            (clk_en),
        .mem_address       (mem_address),
        .mem_mask          (mem_mask),
        .mem_read_fnc_type (mem_read_fnc_type),
        .mem_data          (mem_data),
        .mem_mode          (mem_mode),
        .mem_enable        (mem_enable),
        .mem_wb_dest       (mem_wb_dest),
        .mem_input_ready   (mem_input_ready),
        .mem_data_out      (mem_data_out),
        .mem_wb_dest_out   (mem_wb_dest_out),
        .mem_read_ack      (mem_read_ack),
        .mem_available     (mem_available),
        .mem_idle          (mem_idle),
        .ram_en            (ram_en),
        .ram_we            (ram_we),
        .ram_be            (ram_be),
        .ram_addr          (ram_addr),
        .ram_wdata         (ram_wdata),
        .ram_rdata         (ram_rdata),
`ifdef DATA_MEM_CONTROLLER_PERF_CNT_EN
        .perf_reads        (perf_reads),
        .perf_writes       (perf_writes),
`endif
        .fence_pulse       (fence_pulse),
        .fence_type_out    (fence_type_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM environment model
    logic [15:0] sram [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                if (ram_be[0]) sram[ram_addr][7:0]  <= ram_wdata[7:0];
                if (ram_be[1]) sram[ram_addr][15:8] <= ram_wdata[15:8];
            end else begin
                ram_rdata <= sram[ram_addr];
            end
        end
    end

    int n_chk;
    int n_fail;
    int cyc;
    bit rnd_mode;

    logic [15:0] ref_mem [int];
    logic [19:0] exp_rsp [$];
    logic [1:0]  exp_fence [$];
    int          exp_reads;
    int          exp_writes;
    int          act_writes;
    int          we_cyc [$];
    int          fence_cyc [$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] fmt_ref(input logic [15:0] w,
                                            input logic [1:0] fnc,
                                            input logic [1:0] mask);
        int b;
        b = (mask == 2'b10) ? int'(w[15:8]) : int'(w[7:0]);
        if (fnc == 2'b01) return 16'(b);
        if (fnc == 2'b10) return (b >= 128) ? 16'(b + 65280) : 16'(b);
        return w;
    endfunction

    task automatic model_accept(input logic [1:0] mode, input logic [14:0] addr,
                                input logic [1:0] mask, input logic [1:0] fnc,
                                input logic [15:0] data, input logic [3:0] tag);
        logic [15:0] w;
        if (mode == 2'd0) begin
            exp_rsp.push_back({fmt_ref(ref_mem[int'(addr)], fnc, mask), tag});
            exp_reads++;
        end else if (mode == 2'd1) begin
            w = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 16'h0000;
            if (mask[0]) w[7:0] = data[7:0];
            if (mask[1]) w[15:8] = data[15:8];
            ref_mem[int'(addr)] = w;
            exp_writes++;
        end else begin
            exp_fence.push_back(fnc);
        end
    endtask

    task automatic rnd_ctl();
        if (rnd_mode) begin
            clk_en          = ($urandom_range(0, 9) < 8);
            mem_input_ready = ($urandom_range(0, 9) < 7);
        end
    endtask

    // Starts and ends just after a rising edge.
    task automatic push(input logic [1:0] mode, input logic [14:0] addr,
                        input logic [1:0] mask, input logic [1:0] fnc,
                        input logic [15:0] data, input logic [3:0] tag,
                        output int acc_cyc);
        bit acc;
        acc = 0;
        acc_cyc = -1;
        mem_mode = mode;
        mem_address = addr;
        mem_mask = mask;
        mem_read_fnc_type = fnc;
        mem_data = data;
        mem_wb_dest = tag;
        mem_enable = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = clk_en && mem_available;
            if (acc) begin
                acc_cyc = cyc;
                model_accept(mode, addr, mask, fnc, data, tag);
            end
            @(posedge clk); #1;
            rnd_ctl();
        end
        mem_enable = 1'b0;
        check("push_accepted", 32'(acc), 1);
    endtask

    task automatic wait_ack(output int ack_cyc, output logic [15:0] d,
                            output logic [3:0] t);
        bit got;
        got = 0;
        ack_cyc = -1;
        d = '0;
        t = '0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (mem_read_ack) begin
                got = 1;
                ack_cyc = cyc;
                d = mem_data_out;
                t = mem_wb_dest_out;
            end
            @(posedge clk); #1;
        end
        check("ack_seen", 32'(got), 1);
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = mem_idle && !mem_read_ack;
            @(posedge clk); #1;
        end
        check("drain_idle", 32'(done), 1);
    endtask

    task automatic reset_assert();
        async_rst_n = 1'b0;
        exp_rsp.delete();
        exp_fence.delete();
        exp_reads = 0;
        exp_writes = 0;
        act_writes = 0;
    endtask

    always @(negedge clk) begin
        logic [19:0] e;
        if (async_rst_n) begin
            if (ram_en && ram_we) begin
                act_writes++;
                we_cyc.push_back(cyc);
            end
            if (!clk_en) check("ram_en_gated", 32'(ram_en), 0);
            if (fence_pulse) begin
                fence_cyc.push_back(cyc);
                check("fence_expected", 32'(exp_fence.size() != 0), 1);
                if (exp_fence.size() != 0)
                    check("fence_type", 32'(fence_type_out), 32'(exp_fence.pop_front()));
            end
            if (clk_en && mem_read_ack && mem_input_ready) begin
                check("rsp_expected", 32'(exp_rsp.size() != 0), 1);
                if (exp_rsp.size() != 0) begin
                    e = exp_rsp.pop_front();
                    check("rsp_data", 32'(mem_data_out), 32'(e[19:4]));
                    check("rsp_tag", 32'(mem_wb_dest_out), 32'(e[3:0]));
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  fnc;
        logic [1:0]  mask;
        logic [15:0] exp;
    } fmt_vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        fmt_vec_t    vec [8];
        int          c;
        int          a;
        int          snap;
        logic [15:0] d;
        logic [3:0]  t;
        logic [1:0]  md;
        int          r;
        bit          ord;

        vec[0] = '{2'b00, 2'b11, 16'h80AA};
        vec[1] = '{2'b01, 2'b10, 16'h0080};
        vec[2] = '{2'b10, 2'b10, 16'hFF80};
        vec[3] = '{2'b01, 2'b01, 16'h00AA};
        vec[4] = '{2'b10, 2'b01, 16'hFFAA};
        vec[5] = '{2'b11, 2'b11, 16'h80AA};
        vec[6] = '{2'b10, 2'b11, 16'hFFAA};
        vec[7] = '{2'b01, 2'b11, 16'h00AA};

        n_chk = 0;
        n_fail = 0;
        rnd_mode = 0;
        async_rst_n = 1'b0;
        clk_en = 1'b1;
        mem_enable = 1'b0;
        mem_mode = '0;
        mem_address = '0;
        mem_mask = '0;
        mem_read_fnc_type = '0;
        mem_data = '0;
        mem_wb_dest = '0;
        mem_input_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(mem_read_ack), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        async_rst_n = 1'b1;
        @(negedge clk);
        check("rst_data", 32'(mem_data_out), 0);
        check("rst_tag", 32'(mem_wb_dest_out), 0);
        check("rst_avail", 32'(mem_available), 1);
        check("rst_idle", 32'(mem_idle), 1);
        check("rst_fence", 32'(fence_pulse), 0);
        @(posedge clk); #1;

        // Write then read back with tag 5, latency 3
        snap = act_writes;
        push(2'd1, 15'h0010, 2'b11, 2'b00, 16'hBEEF, 4'd0, c);
        push(2'd0, 15'h0010, 2'b11, 2'b00, 16'h0000, 4'd5, c);
        wait_ack(a, d, t);
        check("t1_latency", 32'(a - c), 3);
        check("t1_data", 32'(d), 32'hBEEF);
        check("t1_tag", 32'(t), 5);
        drain();
        check("t1_we_once", 32'(act_writes - snap), 1);

        // Read formats from a table
        push(2'd1, 15'h0020, 2'b11, 2'b00, 16'h80AA, 4'd0, c);
        foreach (vec[i]) begin
            push(2'd0, 15'h0020, vec[i].mask, vec[i].fnc, 16'h0000, 4'(i), c);
            wait_ack(a, d, t);
            check("fmt_data", 32'(d), 32'(vec[i].exp));
            check("fmt_tag", 32'(t), 32'(i));
        end
        push(2'd1, 15'h0020, 2'b01, 2'b00, 16'h5533, 4'd0, c);
        push(2'd0, 15'h0020, 2'b11, 2'b00, 16'h0000, 4'd2, c);
        wait_ack(a, d, t);
        check("lane_write", 32'(d), 32'h8033);
        drain();

        // Stalled response and a full queue behind it
        mem_input_ready = 1'b0;
        push(2'd0, 15'h0010, 2'b11, 2'b00, 16'h0000, 4'd9, c);
        wait_ack(a, d, t);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ack", 32'(mem_read_ack), 1);
            check("stall_data", 32'(mem_data_out), 32'hBEEF);
            check("stall_tag", 32'(mem_wb_dest_out), 9);
            @(posedge clk); #1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            push(2'd1, 15'(32'h30 + i), 2'b11, 2'b00, 16'(32'h1000 + i), 4'd0, c);
        end
        @(negedge clk);
        check("full_avail", 32'(mem_available), 0);
        check("full_no_sram", 32'(ram_en), 0);
        check("full_ack_held", 32'(mem_read_ack), 1);
        @(posedge clk); #1;
        mem_mode = 2'd1;
        mem_address = 15'h0034;
        mem_mask = 2'b11;
        mem_data = 16'h1004;
        mem_enable = 1'b1;
        mem_input_ready = 1'b1;
        @(negedge clk);
        check("full_blocks", 32'(mem_available), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("pop_cycle_avail", 32'(mem_available), 0);
        check("pop_cycle_we", 32'(ram_we), 1);
        check("pop_cycle_ack", 32'(mem_read_ack), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("avail_back", 32'(mem_available), 1);
        if (mem_available) model_accept(2'd1, 15'h0034, 2'b11, 2'b00, 16'h1004, 4'd0);
        @(posedge clk); #1;
        mem_enable = 1'b0;
        push(2'd0, 15'h0034, 2'b11, 2'b00, 16'h0000, 4'd1, c);
        wait_ack(a, d, t);
        check("fifth_data", 32'(d), 32'h1004);
        drain();

        // Fence between two writes
        we_cyc.delete();
        fence_cyc.delete();
        push(2'd1, 15'h0040, 2'b11, 2'b00, 16'h1111, 4'd0, c);
        push(2'd2, 15'h0000, 2'b00, 2'd2, 16'h0000, 4'd0, c);
        push(2'd1, 15'h0041, 2'b11, 2'b00, 16'h2222, 4'd0, c);
        drain();
        check("fence_we_cnt", 32'(we_cyc.size()), 2);
        check("fence_cnt", 32'(fence_cyc.size()), 1);
        ord = (we_cyc.size() == 2 && fence_cyc.size() == 1) &&
              (we_cyc[0] < fence_cyc[0]) && (fence_cyc[0] < we_cyc[1]);
        check("fence_order", 32'(ord), 1);
        check("fence_idle", 32'(mem_idle), 1);
        check("fence_queue_empty", 32'(exp_fence.size()), 0);

        // Reset during RD_WAIT with a write queued behind
        push(2'd0, 15'h0010, 2'b11, 2'b00, 16'h0000, 4'd6, c);
        push(2'd1, 15'h0050, 2'b11, 2'b00, 16'h7777, 4'd0, c);
        reset_assert();
        #1;
        check("rdw_rst_ack", 32'(mem_read_ack), 0);
        check("rdw_rst_ram_en", 32'(ram_en), 0);
        check("rdw_rst_fence", 32'(fence_pulse), 0);
        @(posedge clk); #1;
        async_rst_n = 1'b1;
        @(negedge clk);
        check("rdw_rel_avail", 32'(mem_available), 1);
        check("rdw_rel_idle", 32'(mem_idle), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rdw_discard_ack", 32'(mem_read_ack), 0);
        end
        check("rdw_discard_we", 32'(act_writes), 0);
        @(posedge clk); #1;

        // Reset while a response is held
        mem_input_ready = 1'b0;
        push(2'd0, 15'h0010, 2'b11, 2'b00, 16'h0000, 4'd3, c);
        wait_ack(a, d, t);
        reset_assert();
        #1;
        check("resp_rst_ack", 32'(mem_read_ack), 0);
        check("resp_rst_data", 32'(mem_data_out), 0);
        check("resp_rst_tag", 32'(mem_wb_dest_out), 0);
        @(posedge clk); #1;
        async_rst_n = 1'b1;
        mem_input_ready = 1'b1;
        @(negedge clk);
        check("resp_rel_idle", 32'(mem_idle), 1);
        @(posedge clk); #1;

        // Randomized traffic against the model
        for (int i = 0; i < 16; i++) begin
            push(2'd1, 15'(i), 2'b11, 2'b00, 16'($urandom), 4'd0, c);
        end
        rnd_mode = 1;
        repeat (300) begin
            r = $urandom_range(0, 9);
            md = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            push(md, 15'($urandom_range(0, 15)),
                 (md == 2'd0) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)), c);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                rnd_ctl();
            end
        end
        rnd_mode = 0;
        clk_en = 1'b1;
        mem_input_ready = 1'b1;
        drain();
        check("rnd_rsp_left", 32'(exp_rsp.size()), 0);
        check("rnd_fence_left", 32'(exp_fence.size()), 0);
        check("rnd_writes", 32'(act_writes), 32'(exp_writes));
`ifdef DATA_MEM_CONTROLLER_PERF_CNT_EN
        check("perf_reads", 32'(perf_reads), 32'(exp_reads));
        check("perf_writes", 32'(perf_writes), 32'(exp_writes));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_controller.md
Name: data_mem_controller

Overview:
- Responder end of the core's load/store memory interface; the core's LSU is the initiator.
- Accepts read, write and fence requests into an in-order request queue and executes them one at a time against a single-port synchronous SRAM.
- Returns tagged, formatted read data with a ready/valid handshake.
- Broadcasts a fence pulse so the instruction cache can invalidate on fences.

Parameters:
DEPTH, 4, request queue entries (power of two, >=2)
RAM_AW, 15, SRAM word-address width

Ports:
clk  in  1  clock (only clock)
async_rst_n  in  1  reset, asynchronous assert, active-low
clk_en  in  1  global clock enable; no state advances when low
mem_address  in  15  request word address
mem_mask  in  2  byte lanes: bit0=[7:0], bit1=[15:8]
mem_read_fnc_type  in  2  read format (read) / fence type (fence)
mem_data  in  16  store data, already lane-aligned
mem_mode  in  2  0=READ, 1=WRITE, 2/3=FENCE
mem_enable  in  1  request valid
mem_wb_dest  in  4  read destination tag
mem_input_ready  in  1  core can accept read response
mem_data_out  out  16  formatted read data
mem_wb_dest_out  out  4  tag of returned read
mem_read_ack  out  1  read response valid
mem_available  out  1  queue can accept a request
mem_idle  out  1  queue empty and no operation in flight
ram_en  out  1  SRAM access enable
ram_we  out  1  SRAM write enable
ram_be  out  2  SRAM byte enables
ram_addr  out  RAM_AW  SRAM address
ram_wdata  out  16  SRAM write data
ram_rdata  in  16  SRAM read data, valid cycle after read access
fence_pulse  out  1  one-cycle pulse when a fence retires
fence_type_out  out  2  fence type, valid with fence_pulse

Behaviour:
- Reset values: queue empty; state IDLE; mem_read_ack=0; mem_data_out=0; mem_wb_dest_out=0; mem_available=1; mem_idle=1; ram_en=0; fence_pulse=0.
- Reset may assert mid-operation. Any in-flight read or held response is discarded.
- Accept: a request is pushed when clk_en && mem_enable && mem_available.
- mem_available = (count != DEPTH), derived from the registered count. A pop in the same cycle does not unblock a push when the queue is full.
- mem_enable while mem_available=0 is ignored. The initiator must hold the request.
- Entry is visible at the queue head on the cycle after the push.
- States: IDLE, RD_WAIT, RESP.
- IDLE, head is WRITE:
  - Pop the entry; drive ram_en=1, ram_we=1, ram_be=mask, ram_addr, ram_wdata combinationally in that cycle.
  - Stay in IDLE. A write costs 1 cycle.
- IDLE, head is READ:
  - Pop the entry; drive ram_en=1, ram_we=0; latch tag, mask and format.
  - Go to RD_WAIT.
- RD_WAIT: capture ram_rdata, format it into the response register, set mem_read_ack=1, go to RESP.
- RESP: hold data, tag and ack stable. When mem_input_ready=1, clear ack and return to IDLE. The next head is not issued in that same cycle.
- Read formats:
  - fnc 00/11: full word.
  - 01: selected byte zero-extended.
  - 10: selected byte sign-extended.
  - Byte is selected by mask (01→[7:0], 10→[15:8]). mask 11 with a byte format selects [7:0].
- IDLE, head is FENCE:
  - Pop the entry; pulse fence_pulse=1 for 1 cycle; fence_type_out=fnc.
  - Stay in IDLE. All older operations are complete by construction (in-order, single outstanding).
- mem_idle = queue empty && state==IDLE.
- Queue pointers wrap modulo DEPTH. Simultaneous push and pop keeps count unchanged.
- clk_en low: all registers hold, and ram_en is forced 0.

Optional Feature:
- Macro DATA_MEM_CONTROLLER_PERF_CNT_EN.
- When defined, adds outputs perf_reads[15:0] and perf_writes[15:0]:
  - Each counts reads/writes issued to the SRAM.
  - Each saturates at 16'hFFFF.
  - Each resets to 0.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Write 0xBEEF to addr 0x0010, mask 11, then read word with tag 5 and mem_input_ready=1: push at T, ack at T+3 with data 0xBEEF and tag 5; ram_we seen exactly once.
- Read byte signed (fnc 10, mask 10) of 0x80AA → 0xFF80. Byte unsigned (fnc 01, mask 10) → 0x0080.
- Hold mem_input_ready=0 for 5 cycles during RESP: data, tag and ack stay stable. No further SRAM access until the handshake completes.
- Push DEPTH requests while a read is stalled in RESP: mem_available drops to 0 after the 4th push. A 5th request is not accepted. mem_available returns to 1 one cycle after the first pop.
- Write, fence type 2, write: fence_pulse high exactly 1 cycle, between the two ram_we cycles, with fence_type_out=2. mem_idle=1 afterwards.
- Assert async_rst_n low during RD_WAIT: mem_read_ack, ram_en and fence_pulse go 0 immediately. mem_available=1 and mem_idle=1 after release.
